// File: rtl/mlp_pkg.sv
// mlp_pkg: shared dense-layer constants, activation typedefs and loader state encoding
package mlp_pkg;
  localparam int N = 16;
  localparam int W = 16;
  typedef logic signed [W-1:0] act_t;
  typedef act_t [N-1:0] act_vec_t;
  typedef enum logic {FILL, HOLD} ld_state_t;
endpackage

// File: rtl/act_vec_loader_if.sv
// act_vec_loader_if: element stream in, held vector out, sticky length error
// master: producer/consumer side; slave: loader side
interface act_vec_loader_if;
  import mlp_pkg::*;
  logic in_valid;
  logic in_ready;
  act_t in_data;
  logic in_last;
  logic vec_valid;
  logic vec_ready;
  act_vec_t vec_data;
  logic err_len;
  modport master (
    output in_valid, in_data, in_last, vec_ready,
    input in_ready, vec_valid, vec_data, err_len
  );
  modport slave (
    input in_valid, in_data, in_last, vec_ready,
    output in_ready, vec_valid, vec_data, err_len
  );
endinterface

// File: rtl/act_bank.sv
// act_bank: N x W register bank, one write port (index, data, clear-others), full-vector read
// ports: clk, rst, i_we, i_idx, i_data, i_clr (zero every other entry on this write), o_vec
module act_bank
  import mlp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [$clog2(N)-1:0] i_idx,
  input  act_t                 i_data,
  input  logic                 i_clr,
  output act_vec_t             o_vec
);
  act_vec_t r_vec;
  always_ff @(posedge clk) begin
    if (rst) r_vec <= '0;
    else if (i_we)
      for (int j = 0; j < N; j++)
        if (j == int'(i_idx)) r_vec[j] <= i_data;
        else if (i_clr) r_vec[j] <= '0;
  end
  assign o_vec = r_vec;
endmodule

// File: rtl/act_vec_loader.sv
// act_vec_loader: assembles N signed activations into a held vector for the dense layer
// ports: clk, rst (sync, active-high), bus (act_vec_loader_if.slave)
// DOUBLE_BUF_EN: ping-pong banks so the next vector fills while the current one is held
module act_vec_loader
  import mlp_pkg::*;
(
  input logic             clk,
  input logic             rst,
  act_vec_loader_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  logic [IW-1:0] r_idx;
  logic r_err;
  logic w_acc, w_done, w_in_ready, w_vec_valid;
  assign w_acc  = bus.in_valid && w_in_ready;
  assign w_done = w_acc && (r_idx == LAST || bus.in_last);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_acc) r_idx <= w_done ? '0 : r_idx + IW'(1);
      r_err <= r_err | (w_acc & ((r_idx == LAST) ^ bus.in_last));
    end
  end
`ifdef DOUBLE_BUF_EN
  logic r_wb, r_rb;
  logic [1:0] r_full;
  logic w_hs;
  act_vec_t w_vec [2];
  assign w_hs = w_vec_valid && bus.vec_ready;
  for (genvar g = 0; g < 2; g++) begin : g_bank
    act_bank u_bank (
      .clk   (clk),
      .rst   (rst),
      .i_we  (w_acc && (r_wb == 1'(g))),
      .i_idx (r_idx),
      .i_data(bus.in_data),
      .i_clr (r_idx == '0),
      .o_vec (w_vec[g])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb   <= 1'b0;
      r_rb   <= 1'b0;
      r_full <= '0;
    end else begin
      if (w_done) begin
        r_full[r_wb] <= 1'b1;
        r_wb         <= ~r_wb;
      end
      if (w_hs) begin
        r_full[r_rb] <= 1'b0;
        r_rb         <= ~r_rb;
      end
    end
  end
  assign w_in_ready   = !r_full[r_wb] && !rst;
  assign w_vec_valid  = r_full[r_rb] && !rst;
  assign bus.vec_data = w_vec[r_rb];
`else
  ld_state_t r_st;
  logic r_in_ready, r_vec_valid;
  act_vec_t w_vec;
  act_bank u_bank (
    .clk   (clk),
    .rst   (rst),
    .i_we  (w_acc),
    .i_idx (r_idx),
    .i_data(bus.in_data),
    .i_clr (r_idx == '0),
    .o_vec (w_vec)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st        <= FILL;
      r_in_ready  <= 1'b1;
      r_vec_valid <= 1'b0;
    end else if (r_st == FILL && w_done) begin
      r_st        <= HOLD;
      r_in_ready  <= 1'b0;
      r_vec_valid <= 1'b1;
    end else if (r_st == HOLD && bus.vec_ready) begin
      r_st        <= FILL;
      r_in_ready  <= 1'b1;
      r_vec_valid <= 1'b0;
    end
  end
  assign w_in_ready   = r_in_ready && !rst;
  assign w_vec_valid  = r_vec_valid && !rst;
  assign bus.vec_data = w_vec;
`endif
  assign bus.in_ready  = w_in_ready;
  assign bus.vec_valid = w_vec_valid;
  assign bus.err_len   = r_err;
endmodule

// File: tb/tb_act_vec_loader.sv
// tb_act_vec_loader: directed, table-driven and random checks of act_vec_loader against a stream model
module tb_act_vec_loader;
  import mlp_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  act_vec_loader_if bus ();
  act_vec_loader dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0, stall_cnt = 0, hs_cnt = 0, cyc = 0, rdy_mode = 1;
  bit m_err;
  act_t cur[$];
  act_vec_t exp_q[$];
  bit mon_held;
  act_vec_t mon_hd;
  typedef struct {
    int   len;
    int   last_at;
    int   base;
    int   step;
    int   gap;
    logic exp_err;
  } vec_rec_t;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic finish_run;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask
  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", nm);
    finish_run();
  endtask
  task automatic model_push(input act_t v, input bit last);
    act_vec_t e;
    cur.push_back(v);
    if (last || cur.size() == N) begin
      e = '0;
      for (int i = 0; i < cur.size(); i++) e[i] = cur[i];
      m_err = m_err | (cur.size() != N) | !last;
      exp_q.push_back(e);
      cur.delete();
    end
  endtask
  task automatic send(input act_t v, input bit last, input int gap);
    repeat (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    bus.in_last  = last;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      stall_cnt++;
      if (t == 300) timeout("send_accept");
    end
    model_push(v, last);
    @(posedge clk); #1;
  endtask
  task automatic send_vec(input int base, input int step, input int len, input int last_at, input int gap);
    for (int i = 0; i < len; i++) send(act_t'(base + i * step), i == last_at, $urandom_range(0, gap));
    bus.in_valid = 1'b0;
  endtask
  task automatic drain;
    bus.in_valid = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (exp_q.size() == 0 && !bus.vec_valid) break;
      if (t == 399) timeout("drain");
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_data = '0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_vec_valid", bus.vec_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_vec_data", bus.vec_data, 0);
    chk("rst_err_len", bus.err_len, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cur.delete();
    exp_q.delete();
    m_err = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
  endtask
  initial begin
    bus.vec_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.vec_ready = (rdy_mode == 2) ? ($urandom_range(0, 1) != 0) : (rdy_mode == 1);
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (rst) mon_held = 1'b0;
      else begin
        if (mon_held) begin
          chk("hold_valid", bus.vec_valid, 1);
          chk("hold_data", bus.vec_data, mon_hd);
        end
        if (bus.vec_valid && bus.vec_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_vec: got %h expected no vector", bus.vec_data);
          end else chk("vec_data", bus.vec_data, exp_q.pop_front());
        end
        mon_held = bus.vec_valid && !bus.vec_ready;
        mon_hd   = bus.vec_data;
      end
    end
  end
  initial begin
    #500000;
    timeout("watchdog");
  end
  initial begin
    vec_rec_t tbl[5];
    act_vec_t e, d;
    act_t sv[5];
    int c0, c1, len;
    bit last;
    tbl[0] = '{16, 15, 1000, 1, 0, 1'b0};
    tbl[1] = '{16, -1, -50, -3, 1, 1'b1};
    tbl[2] = '{3, 2, 32767, -1, 0, 1'b1};
    tbl[3] = '{1, 0, -32768, 0, 2, 1'b1};
    tbl[4] = '{16, 15, -32768, 4096, 1, 1'b0};
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_data = '0;
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < 15; i++) send(act_t'(i + 1), 1'b0, 0);
    chk("pre_complete_valid", bus.vec_valid, 0);
    send(act_t'(16), 1'b1, 0);
    chk("latency_valid", bus.vec_valid, 1);
    for (int i = 0; i < N; i++) e[i] = act_t'(i + 1);
    chk("seq_vec", bus.vec_data, e);
    chk("seq_err", bus.err_len, 0);
    drain();
    rdy_mode = 0;
    send_vec(-7, 13, 16, 15, 0);
    d = bus.vec_data;
`ifdef DOUBLE_BUF_EN
    fork
      begin
        for (int i = 0; i < 16; i++) send(act_t'(200 + i), i == 15, 0);
      end
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("held_data", bus.vec_data, d);
        end
      end
    join
    bus.in_valid = 1'b0;
    chk("dbl_full_in_ready", bus.in_ready, 0);
`else
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("held_data", bus.vec_data, d);
      chk("held_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1;
`endif
    rdy_mode = 1;
    drain();
    do_reset();
    sv = '{-3, -2, -1, 0, 7};
    e = '0;
    for (int i = 0; i < 5; i++) begin
      send(sv[i], i == 4, 0);
      e[i] = sv[i];
    end
    bus.in_valid = 1'b0;
    chk("short_vec", bus.vec_data, e);
    chk("short_err", bus.err_len, 1);
    drain();
    do_reset();
    send_vec(40, -9, 16, -1, 0);
    chk("nolast_valid", bus.vec_valid, 1);
    chk("nolast_err", bus.err_len, 1);
    send_vec(-500, 77, 16, 15, 1);
    drain();
    chk("nolast_sticky_err", bus.err_len, 1);
    do_reset();
    send_vec(9, 9, 7, -1, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_vec_valid", bus.vec_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cur.delete();
    exp_q.delete();
    m_err = 1'b0;
    send_vec(100, 1, 16, 15, 0);
    for (int i = 0; i < N; i++) e[i] = act_t'(100 + i);
    chk("midrst_vec", bus.vec_data, e);
    drain();
    chk("midrst_err", bus.err_len, 0);
    for (int k = 0; k < 5; k++) begin
      do_reset();
      rdy_mode = 2;
      send_vec(tbl[k].base, tbl[k].step, tbl[k].len, tbl[k].last_at, tbl[k].gap);
      drain();
      chk("tbl_err", bus.err_len, tbl[k].exp_err);
    end
    do_reset();
    rdy_mode = 2;
    for (int v = 0; v < 40; v++) begin
      len  = $urandom_range(1, N);
      last = !(len == N && $urandom_range(0, 2) == 0);
      for (int i = 0; i < len; i++)
        send(act_t'($urandom), last && (i == len - 1), $urandom_range(0, 2));
    end
    drain();
    chk("rand_err", bus.err_len, m_err);
    do_reset();
    rdy_mode = 1;
    stall_cnt = 0;
    hs_cnt = 0;
    c0 = cyc;
    for (int v = 0; v < 4; v++)
      for (int i = 0; i < 16; i++) send(act_t'(v * 16 + i - 30), i == 15, 0);
    c1 = cyc;
    drain();
    chk("tput_handshakes", hs_cnt, 4);
`ifdef DOUBLE_BUF_EN
    chk("tput_cycles", c1 - c0, 64);
    chk("tput_stalls", stall_cnt, 0);
`else
    chk("tput_cycles", c1 - c0, 67);
    chk("tput_stalls", stall_cnt, 3);
`endif
    finish_run();
  end
endmodule
